// File: rtl/cpu_mc_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mc_pkg
// Shared definitions for the multi-cycle core: opcode and FSM state
// enumerations, instruction field geometry and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_mc_pkg;

   // Instruction field geometry. The opcode sits in the top OP_W bits,
   // followed by rd and rs (RA bits each), with an 8-bit immediate at the bottom.
   localparam int OP_W    = 4;
   localparam int IMM_W   = 8;
   localparam int IMM_LSB = 0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_ADDI = 4'd5,
      OP_LD   = 4'd6,
      OP_ST   = 4'd7,
      OP_BEQZ = 4'd8,
      OP_JMP  = 4'd9,
      OP_HALT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Opcodes 10..14 are unassigned and are treated exactly like HALT.
   function automatic logic is_halt_op(input logic [OP_W-1:0] op);
      return (op >= 4'd10);
   endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// -----------------------------------------------------------------------------
// cpu_mc_regfile
// General register file: REG_CNT x DATA_W, two asynchronous read ports and
// one synchronous write port. Synchronous active-high reset clears all entries.
//   clk        in  clock
//   i_rst      in  synchronous reset, active high
//   i_we       in  write enable
//   i_waddr    in  write index
//   i_wdata    in  write data
//   i_raddr_a  in  read port A index    o_rdata_a  out  read port A data
//   i_raddr_b  in  read port B index    o_rdata_b  out  read port B data
// -----------------------------------------------------------------------------
module cpu_mc_regfile
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 4
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_we,
   input  logic [$clog2(REG_CNT)-1:0] i_waddr,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic [$clog2(REG_CNT)-1:0] i_raddr_a,
   output logic [DATA_W-1:0]          o_rdata_a,
   input  logic [$clog2(REG_CNT)-1:0] i_raddr_b,
   output logic [DATA_W-1:0]          o_rdata_b
);

   logic [DATA_W-1:0] r_regs [REG_CNT];

   // Register storage: cleared on reset, single write port otherwise.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int i = 0; i < REG_CNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_regs[i_raddr_a];
   assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_mc_core.sv
// -----------------------------------------------------------------------------
// cpu_mc_core
// Multi-cycle accumulator-free load/store core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with a single request/ready memory port.
//   clk        in   clock, all state on rising edge
//   rst_b      in   synchronous reset, active high
//   mem_req    out  memory access request
//   mem_we     out  1 = write, 0 = read (valid with mem_req)
//   mem_addr   out  byte address of the access
//   mem_wdata  out  store data
//   mem_rdata  in   read data, valid when mem_ready=1
//   mem_ready  in   access completes when mem_req=1 and mem_ready=1
//   halted     out  core is in HALT
//   pc_o       out  current PC
// -----------------------------------------------------------------------------
module cpu_mc_core
   import cpu_mc_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                REG_CNT  = 4,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_b,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [DATA_W-1:0] pc_o
);

   localparam int RA     = $clog2(REG_CNT);
   localparam int RD_MSB = DATA_W - OP_W - 1;
   localparam int RS_MSB = RD_MSB - RA;
   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

   state_e            r_state;
   state_e            w_state_nx;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_res;
   // Set by reset; suppresses the fetch request for the first cycle after
   // reset so that a ready left over from an abandoned access is not taken.
   logic              r_rst_seen;

   logic [OP_W-1:0]   w_op;
   logic [RA-1:0]     w_rd;
   logic [RA-1:0]     w_rs;
   logic [DATA_W-1:0] w_imm_sx;
   logic [DATA_W-1:0] w_br_off;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic              w_mem_req;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_acc_done;

   assign w_op     = r_ir[DATA_W-1 -: OP_W];
   assign w_rd     = r_ir[RD_MSB -: RA];
   assign w_rs     = r_ir[RS_MSB -: RA];
   assign w_imm_sx = {{(DATA_W-IMM_W){r_ir[IMM_LSB+IMM_W-1]}}, r_ir[IMM_LSB +: IMM_W]};
   // Branch offset counts halfwords: imm << 1.
   assign w_br_off = {w_imm_sx[DATA_W-2:0], 1'b0};
   assign w_acc_done = w_mem_req & mem_ready;

   cpu_mc_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT)
   ) u_regfile (
      .clk       (clk),
      .i_rst     (rst_b),
      .i_we      (r_state == ST_WB),
      .i_waddr   (w_rd),
      .i_wdata   (r_res),
      .i_raddr_a (w_rd),
      .o_rdata_a (w_rd_a),
      .i_raddr_b (w_rs),
      .o_rdata_b (w_rd_b)
   );

   // Next-state and memory-port decode from the current state.
   always_comb begin
      w_state_nx  = r_state;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_pc;
      w_mem_wdata = '0;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = ~r_rst_seen;
            if (w_mem_req && mem_ready) begin
               w_state_nx = ST_DECODE;
            end else begin
               w_state_nx = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (is_halt_op(w_op)) begin
               w_state_nx = ST_HALT;
            end else begin
               w_state_nx = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (w_op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: w_state_nx = ST_WB;
               OP_LD, OP_ST:                           w_state_nx = ST_MEM;
               default:                                w_state_nx = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            w_mem_req  = 1'b1;
            w_mem_addr = r_b;
            w_mem_we   = (w_op == OP_ST);
            if (w_mem_we) begin
               w_mem_wdata = r_a;
            end else begin
               w_mem_wdata = '0;
            end
            if (mem_ready) begin
               w_state_nx = w_mem_we ? ST_FETCH : ST_WB;
            end else begin
               w_state_nx = ST_MEM;
            end
         end
         ST_WB:   w_state_nx = ST_FETCH;
         ST_HALT: w_state_nx = ST_HALT;
         default: w_state_nx = ST_FETCH;
      endcase
   end

   // Datapath and state register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state    <= ST_FETCH;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_rst_seen <= 1'b1;
      end else begin
         r_state    <= w_state_nx;
         r_rst_seen <= 1'b0;
         case (r_state)
            ST_FETCH: begin
               if (w_acc_done) begin
                  r_ir <= mem_rdata;
                  r_pc <= r_pc + PC_STEP;
               end
            end
            ST_DECODE: begin
               r_a <= w_rd_a;
               r_b <= w_rd_b;
            end
            ST_EXEC: begin
               case (w_op)
                  OP_ADD:  r_res <= r_a + r_b;
                  OP_SUB:  r_res <= r_a - r_b;
                  OP_AND:  r_res <= r_a & r_b;
                  OP_OR:   r_res <= r_a | r_b;
                  OP_ADDI: r_res <= r_a + w_imm_sx;
                  // pc already points past this instruction here.
                  OP_BEQZ: begin
                     if (r_a == '0) begin
                        r_pc <= r_pc + w_br_off;
                     end
                  end
                  OP_JMP:  r_pc <= r_b;
                  default: r_res <= r_res;
               endcase
            end
            ST_MEM: begin
               if (w_acc_done && (w_op == OP_LD)) begin
                  r_res <= mem_rdata;
               end
            end
            default: r_res <= r_res;
         endcase
      end
   end

   assign mem_req   = w_mem_req;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;
   assign halted    = (r_state == ST_HALT);
   assign pc_o      = r_pc;

endmodule
